// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU (LO <= quotient, HI <= remainder).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one edge and the div_zero port is added.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  input  logic             result_ack,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FAST_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dsr_abs_r;
  logic               dvd_neg_r;
  logic               dsr_neg_r;
  logic               zero_r;

  logic               accept_s;
  logic               dvd_in_neg_s;
  logic               dsr_in_neg_s;
  logic               last_step_s;
  logic               fast_zero_s;
  logic               load_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   res_q_s;
  logic [WIDTH-1:0]   res_r_s;

  assign accept_s     = (state_r == IDLE) && start && !annul;
  assign dvd_in_neg_s = is_signed & dividend[WIDTH-1];
  assign dsr_in_neg_s = is_signed & divisor[WIDTH-1];
  assign last_step_s  = (cnt_r == CW'(WIDTH - 1));
  assign shift_s      = {rem_r, quo_r[WIDTH-1]};
  assign trial_s      = shift_s - {1'b0, dsr_abs_r};
  assign load_s       = (state_nxt_s == DONE) && (state_r != DONE);

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero_s = (divisor == {WIDTH{1'b0}});
`else
  assign fast_zero_s = 1'b0;
`endif

  // Next-state logic; annul overrides every other request.
  always_comb begin
    state_nxt_s = state_r;
    if (annul) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nxt_s = fast_zero_s ? DONE : BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY: begin
          if (last_step_s) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        FIX:  state_nxt_s = DONE;
        DONE: begin
          if (result_ack) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Sign correction; a zero divisor returns all ones and restores the dividend bit pattern.
  always_comb begin
    res_q_s = {WIDTH{1'b1}};
    res_r_s = dividend;
    if (state_r == IDLE) begin
      res_q_s = {WIDTH{1'b1}};
      res_r_s = dividend;
    end else if (zero_r) begin
      res_q_s = {WIDTH{1'b1}};
      res_r_s = dvd_neg_r ? negate(rem_r) : rem_r;
    end else begin
      res_q_s = (dvd_neg_r ^ dsr_neg_r) ? negate(quo_r) : quo_r;
      res_r_s = dvd_neg_r ? negate(rem_r) : rem_r;
    end
  end

  // Operand capture and one restoring step per BUSY cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r     <= {CW{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      dsr_abs_r <= {WIDTH{1'b0}};
      dvd_neg_r <= 1'b0;
      dsr_neg_r <= 1'b0;
      zero_r    <= 1'b0;
    end else if (accept_s) begin
      cnt_r     <= {CW{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= dvd_in_neg_s ? negate(dividend) : dividend;
      dsr_abs_r <= dsr_in_neg_s ? negate(divisor) : divisor;
      dvd_neg_r <= dvd_in_neg_s;
      dsr_neg_r <= dsr_in_neg_s;
      zero_r    <= (divisor == {WIDTH{1'b0}});
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      if (!trial_s[WIDTH]) begin
        rem_r <= trial_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shift_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // State register and registered outputs; results only change on entry to DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      quotient     <= {WIDTH{1'b0}};
      remainder    <= {WIDTH{1'b0}};
`ifdef DIV_ZERO_FAST_EN
      div_zero     <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      busy         <= (state_nxt_s == BUSY) || (state_nxt_s == FIX);
      result_valid <= (state_nxt_s == DONE);
      if (load_s) begin
        quotient  <= res_q_s;
        remainder <= res_r_s;
      end
`ifdef DIV_ZERO_FAST_EN
      div_zero <= (state_nxt_s == DONE) && ((state_r == IDLE) || div_zero);
`endif
    end
  end

endmodule
